// File: rtl/pqr5_core_pkg.sv
// Shared core definitions: access sizes, memory command encodings and the
// data-memory arbiter state type.
package pqr5_core_pkg;

  localparam logic [1:0] BYTE  = 2'd0;
  localparam logic [1:0] HWORD = 2'd1;
  localparam logic [1:0] WORD  = 2'd2;

  localparam logic LOAD  = 1'b0;
  localparam logic STORE = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RSP
  } arb_state_e;

endpackage

// File: rtl/dmem_be_gen.sv
// Byte-enable generation from access size and low address bits, plus a
// misalignment flag that is only raised when CHK_EN is set.
module dmem_be_gen
  import pqr5_core_pkg::*;
#(
  parameter bit CHK_EN = 1'b0
) (
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_o,
  output logic       misalign_o
);

  logic misalign_raw;

  always_comb begin
    be_o         = '1;
    misalign_raw = 1'b0;
    case (size_i)
      BYTE: be_o = 4'b0001 << addr_lo_i;
      // Upper lane of an HWORD at offset 3 falls off the 4-bit shift.
      HWORD: begin
        be_o         = 4'b0011 << addr_lo_i;
        misalign_raw = addr_lo_i[0];
      end
      default: begin
        be_o         = '1;
        misalign_raw = |addr_lo_i;
      end
    endcase
    misalign_o = CHK_EN & misalign_raw;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: LSU vs debug/loader, one transaction outstanding,
// responses tagged by requester. Define MISALIGN_CHK_EN to fault misaligned accesses.
module dmem_arbiter
  import pqr5_core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic            i_lsu_cmd,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [1:0]      i_lsu_size,
  input  logic [XLEN-1:0] i_lsu_wdata,
  input  logic            i_dbg_valid,
  output logic            o_dbg_ready,
  input  logic            i_dbg_cmd,
  input  logic [XLEN-1:0] i_dbg_addr,
  input  logic [XLEN-1:0] i_dbg_wdata,
  output logic            o_rsp_valid,
  output logic            o_rsp_id,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_mem_req,
  input  logic            i_mem_gnt,
  output logic            o_mem_cmd,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [3:0]      o_mem_be,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);

`ifdef MISALIGN_CHK_EN
  localparam bit MisalignChk = 1'b1;
`else
  localparam bit MisalignChk = 1'b0;
`endif

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] StreakMax = SW'(MAX_STREAK);

  arb_state_e      state_q, state_d;
  logic            cmd_q, cmd_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            id_q, id_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            lsu_win, dbg_win, accept;
  logic [XLEN-1:0] sel_addr;
  logic [1:0]      sel_size;
  logic [3:0]      be_w;
  logic            misalign_w;

  // Debug only wins once the LSU has used up its streak allowance.
  assign lsu_win     = i_lsu_valid && !(i_dbg_valid && (streak_q == StreakMax));
  assign dbg_win     = i_dbg_valid && !lsu_win;
  assign o_lsu_ready = (state_q == ARB_IDLE) && lsu_win;
  assign o_dbg_ready = (state_q == ARB_IDLE) && dbg_win;
  assign accept      = o_lsu_ready || o_dbg_ready;
  assign sel_addr    = dbg_win ? i_dbg_addr : i_lsu_addr;
  assign sel_size    = dbg_win ? WORD : i_lsu_size;

  dmem_be_gen #(
    .CHK_EN(MisalignChk)
  ) u_be_gen (
    .size_i    (sel_size),
    .addr_lo_i (sel_addr[1:0]),
    .be_o      (be_w),
    .misalign_o(misalign_w)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    id_d        = id_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          cmd_d   = dbg_win ? i_dbg_cmd : i_lsu_cmd;
          addr_d  = {sel_addr[XLEN-1:2], 2'b00};
          be_d    = be_w;
          wdata_d = dbg_win ? i_dbg_wdata : i_lsu_wdata;
          id_d    = dbg_win;
          if (misalign_w) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = dbg_win;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ARB_REQ;
          end
        end
      end
      ARB_REQ: begin
        if (i_mem_gnt) begin
          if (cmd_q == STORE) begin
            state_d     = ARB_IDLE;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
          end else if (i_mem_rvalid) begin
            state_d     = ARB_IDLE;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_rdata_d = i_mem_rdata;
          end else begin
            state_d = ARB_RSP;
          end
        end
      end
      ARB_RSP: begin
        if (i_mem_rvalid) begin
          state_d     = ARB_IDLE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_rdata_d = i_mem_rdata;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (!i_dbg_valid || o_dbg_ready) begin
      streak_d = '0;
    end else if (o_lsu_ready && (streak_q != StreakMax)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= ARB_IDLE;
      cmd_q       <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      id_q        <= 1'b0;
      streak_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      id_q        <= id_d;
      streak_q    <= streak_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_mem_req   = (state_q == ARB_REQ);
  assign o_mem_cmd   = cmd_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_be    = be_q;
  assign o_mem_wdata = wdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares each response pulse.
module tb_dmem_arbiter;
  import pqr5_core_pkg::*;

  logic        clk = 1'b0;
  logic        areset;
  logic        i_lsu_valid, o_lsu_ready, i_lsu_cmd;
  logic [31:0] i_lsu_addr, i_lsu_wdata;
  logic [1:0]  i_lsu_size;
  logic        i_dbg_valid, o_dbg_ready, i_dbg_cmd;
  logic [31:0] i_dbg_addr, i_dbg_wdata;
  logic        o_rsp_valid, o_rsp_id, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic        o_mem_req, i_mem_gnt, o_mem_cmd, i_mem_rvalid;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic [3:0]  o_mem_be;

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  dmem_arbiter #(.XLEN(32), .MAX_STREAK(4)) dut (
    .clk(clk), .areset(areset),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_cmd(i_lsu_cmd),
    .i_lsu_addr(i_lsu_addr), .i_lsu_size(i_lsu_size), .i_lsu_wdata(i_lsu_wdata),
    .i_dbg_valid(i_dbg_valid), .o_dbg_ready(o_dbg_ready), .i_dbg_cmd(i_dbg_cmd),
    .i_dbg_addr(i_dbg_addr), .i_dbg_wdata(i_dbg_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err),
    .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_cmd(o_mem_cmd),
    .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!areset && o_rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual id=%0d rdata=%h required=no response",
                 o_rsp_id, o_rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", {31'd0, o_rsp_id}, {31'd0, mon_e.id});
        chk("rsp_rdata", o_rsp_rdata, mon_e.rdata);
        chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic do_req(input bit dbg, input logic cmd, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input bit push, input logic [31:0] exp_rdata, input logic exp_err);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (dbg) begin
      i_dbg_valid = 1'b1; i_dbg_cmd = cmd; i_dbg_addr = addr; i_dbg_wdata = wdata;
    end else begin
      i_lsu_valid = 1'b1; i_lsu_cmd = cmd; i_lsu_addr = addr; i_lsu_size = size;
      i_lsu_wdata = wdata;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = dbg ? o_dbg_ready : o_lsu_ready;
      if (!got) @(posedge clk);
    end
    chk("accept", {31'd0, got}, 32'd1);
    if (got && push) exp_q.push_back('{id: dbg, rdata: exp_rdata, err: exp_err});
    @(posedge clk); #1;
    i_lsu_valid = 1'b0;
    i_dbg_valid = 1'b0;
  endtask

  task automatic mem_serve(input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           input logic cmd, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      chk("req_held", {31'd0, o_mem_req}, 32'd1);
      chk("addr_held", o_mem_addr, addr);
      chk("be_held", {28'd0, o_mem_be}, {28'd0, be});
      @(posedge clk); #1;
    end
    i_mem_gnt = 1'b1;
    if (cmd == LOAD && rv_dly == 0) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = rdata;
    end
    @(negedge clk);
    chk("mem_req", {31'd0, o_mem_req}, 32'd1);
    chk("mem_cmd", {31'd0, o_mem_cmd}, {31'd0, cmd});
    chk("mem_addr", o_mem_addr, addr);
    chk("mem_be", {28'd0, o_mem_be}, {28'd0, be});
    if (cmd == STORE) chk("mem_wdata", o_mem_wdata, wdata);
    @(posedge clk); #1;
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    if (cmd == LOAD && rv_dly > 0) begin
      for (int i = 1; i < rv_dly; i++) begin
        @(negedge clk);
        chk("req_low_wait", {31'd0, o_mem_req}, 32'd0);
        @(posedge clk); #1;
      end
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = rdata;
      @(posedge clk); #1;
      i_mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] order;
    int         n;
    areset = 1'b1;
    i_lsu_valid = 1'b0; i_lsu_cmd = 1'b0; i_lsu_addr = '0; i_lsu_size = '0; i_lsu_wdata = '0;
    i_dbg_valid = 1'b0; i_dbg_cmd = 1'b0; i_dbg_addr = '0; i_dbg_wdata = '0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_mem_outs", {o_mem_cmd, o_mem_be, o_rsp_id, o_rsp_err}, 32'd0);
    chk("rst_mem_addr", o_mem_addr | o_mem_wdata | o_rsp_rdata, 32'd0);
    @(posedge clk); #1;
    areset = 1'b0;

    // Word store, immediate grant, response at cycle 2
    do_req(0, STORE, 32'h100, WORD, 32'hDEADBEEF, 1, 32'h0, 1'b0);
    mem_serve(0, 0, 32'h0, STORE, 4'b1111, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    chk("store_rsp_c2", {31'd0, o_rsp_valid}, 32'd1);

    // Byte load at 0x103, grant after 3 waits, rvalid 2 cycles after grant
    do_req(0, LOAD, 32'h103, BYTE, 32'h0, 1, 32'h11223344, 1'b0);
    mem_serve(3, 2, 32'h11223344, LOAD, 4'b1000, 32'h100, 32'h0);

    // Zero-wait load: gnt and rvalid together
    do_req(0, LOAD, 32'h204, WORD, 32'h0, 1, 32'hCAFEF00D, 1'b0);
    mem_serve(0, 0, 32'hCAFEF00D, LOAD, 4'b1111, 32'h204, 32'h0);
    @(negedge clk);
    chk("load_rsp_c2", {31'd0, o_rsp_valid}, 32'd1);

    // Debug load is always WORD regardless of LSU size lines
    do_req(1, LOAD, 32'h208, BYTE, 32'h0, 1, 32'h0BADC0DE, 1'b0);
    mem_serve(1, 1, 32'h0BADC0DE, LOAD, 4'b1111, 32'h208, 32'h0);

    do_req(0, STORE, 32'h102, HWORD, 32'hBEEF0000, 1, 32'h0, 1'b0);
    mem_serve(0, 0, 32'h0, STORE, 4'b1100, 32'h100, 32'hBEEF0000);
    do_req(0, STORE, 32'h101, BYTE, 32'h0000AA00, 1, 32'h0, 1'b0);
    mem_serve(0, 0, 32'h0, STORE, 4'b0010, 32'h100, 32'h0000AA00);

`ifdef MISALIGN_CHK_EN
    do_req(0, STORE, 32'h101, HWORD, 32'h00ABCD00, 1, 32'h0, 1'b1);
    @(negedge clk);
    chk("misalign_no_req", {31'd0, o_mem_req}, 32'd0);
    chk("misalign_rsp_c1", {31'd0, o_rsp_valid}, 32'd1);
`else
    do_req(0, STORE, 32'h101, HWORD, 32'h00ABCD00, 1, 32'h0, 1'b0);
    mem_serve(0, 0, 32'h0, STORE, 4'b0110, 32'h100, 32'h00ABCD00);
`endif

    // Both requesters continuously valid: expect L,L,L,L,D,L,L,L,L,D
    @(posedge clk); #1;
    i_mem_gnt = 1'b1;
    i_lsu_valid = 1'b1; i_lsu_cmd = STORE; i_lsu_addr = 32'h300; i_lsu_size = WORD;
    i_lsu_wdata = 32'h33;
    i_dbg_valid = 1'b1; i_dbg_cmd = STORE; i_dbg_addr = 32'h400; i_dbg_wdata = 32'h44;
    order = '0;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk);
      if (o_lsu_ready || o_dbg_ready) begin
        chk("one_ready", {31'd0, o_lsu_ready & o_dbg_ready}, 32'd0);
        order[n] = o_dbg_ready;
        exp_q.push_back('{id: o_dbg_ready, rdata: 32'h0, err: 1'b0});
        n++;
      end
    end
    @(posedge clk); #1;
    i_lsu_valid = 1'b0;
    i_dbg_valid = 1'b0;
    @(posedge clk); #1;
    i_mem_gnt = 1'b0;
    chk("grant_count", n, 32'd10);
    chk("grant_order", {22'd0, order}, {22'd0, 10'b1000010000});

    // Reset while waiting in RSP drops the transaction silently
    do_req(0, LOAD, 32'h500, WORD, 32'h0, 0, 32'h0, 1'b0);
    i_mem_gnt = 1'b1;
    @(posedge clk); #1;
    i_mem_gnt = 1'b0;
    @(negedge clk);
    chk("rsp_state_no_req", {31'd0, o_mem_req}, 32'd0);
    #1 areset = 1'b1;
    #2;
    chk("rst_mid_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_mid_be", {28'd0, o_mem_be}, 32'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h55;
    @(posedge clk); #1;
    i_mem_rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {31'd0, o_rsp_valid}, 32'd0);
    end
    do_req(0, STORE, 32'h600, HWORD, 32'h00001234, 1, 32'h0, 1'b0);
    mem_serve(0, 0, 32'h0, STORE, 4'b0011, 32'h600, 32'h00001234);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
